// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - FSM state and owner codes shared by the unified-memory arbiter
package riscv_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_REQ  = 2'd1;
  localparam arb_state_t ARB_RSP  = 2'd2;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

endpackage

// File: rtl/riscv_mem_arb_starve.sv
// rtl/riscv_mem_arb_starve.sv - counts consecutive data grants while fetch waits
// Built only when RISCV_ARB_STARVE_GUARD_EN is defined.
module riscv_mem_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_req,
  input  logic grant_fetch,
  input  logic grant_data,
  output logic starve
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_MAX);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (grant_fetch || !fetch_req) begin
      count <= '0;
    end else if (grant_data && count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign starve = (count == LIMIT);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - one-outstanding-transaction arbiter for IF/MEM over a shared memory
// Optional fetch starvation guard: RISCV_ARB_STARVE_GUARD_EN.
import riscv_pkg::*;

module riscv_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            iclk,
  input  logic            irst,
  input  logic            ifetch_req,
  input  logic [AW-1:0]   ifetch_addr,
  output logic [DW-1:0]   ofetch_rdata,
  output logic            ofetch_valid,
  output logic            ostall_f,
  input  logic            idata_req,
  input  logic            idata_we,
  input  logic [AW-1:0]   idata_addr,
  input  logic [DW-1:0]   idata_wdata,
  input  logic [DW/8-1:0] idata_be,
  output logic [DW-1:0]   odata_rdata,
  output logic            odata_done,
  output logic            ostall_m,
  output logic            omem_req,
  output logic            omem_we,
  output logic [AW-1:0]   omem_addr,
  output logic [DW-1:0]   omem_wdata,
  output logic [DW/8-1:0] omem_be,
  input  logic            imem_ack,
  input  logic            imem_rvalid,
  input  logic [DW-1:0]   imem_rdata
);

  arb_state_t        state;
  logic              owner;
  logic              we;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   be;
  logic              starve;
  logic              grant_fetch;
  logic              grant_data;

  // Data is the older instruction, so it wins unless the guard forces a fetch.
  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (state == ARB_IDLE) begin
      if (ifetch_req && (!idata_req || starve)) begin
        grant_fetch = 1'b1;
      end else if (idata_req) begin
        grant_data = 1'b1;
      end
    end
  end

`ifdef RISCV_ARB_STARVE_GUARD_EN
  riscv_mem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk         (iclk),
    .rst         (irst),
    .fetch_req   (ifetch_req),
    .grant_fetch (grant_fetch),
    .grant_data  (grant_data),
    .starve      (starve)
  );
`else
  // Never true: strict data priority.
  assign starve = (STARVE_MAX < 0);
`endif

  always_ff @(posedge iclk) begin
    if (irst) begin
      state        <= ARB_IDLE;
      owner        <= OWN_FETCH;
      we           <= 1'b0;
      addr         <= '0;
      wdata        <= '0;
      be           <= '0;
      ofetch_valid <= 1'b0;
      odata_done   <= 1'b0;
      ofetch_rdata <= '0;
      odata_rdata  <= '0;
    end else begin
      ofetch_valid <= 1'b0;
      odata_done   <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_data) begin
            owner <= OWN_DATA;
            addr  <= idata_addr;
            we    <= idata_we;
            wdata <= idata_wdata;
            be    <= idata_we ? idata_be : '1;
            state <= ARB_REQ;
          end else if (grant_fetch) begin
            owner <= OWN_FETCH;
            addr  <= ifetch_addr;
            we    <= 1'b0;
            wdata <= '0;
            be    <= '1;
            state <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (imem_ack) begin
            if (we) begin
              odata_done <= 1'b1;
              state      <= ARB_IDLE;
            end else begin
              state <= ARB_RSP;
            end
          end
        end
        ARB_RSP: begin
          if (imem_rvalid) begin
            if (owner == OWN_DATA) begin
              odata_rdata <= imem_rdata;
              odata_done  <= 1'b1;
            end else begin
              ofetch_rdata <= imem_rdata;
              ofetch_valid <= 1'b1;
            end
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign omem_req   = (state == ARB_REQ);
  assign omem_we    = omem_req & we;
  assign omem_addr  = addr;
  assign omem_wdata = wdata;
  assign omem_be    = be;

  assign ostall_f = ifetch_req & ~ofetch_valid;
  assign ostall_m = idata_req & ~odata_done;

endmodule
